// File: rtl/prog_encoder.sv
// prog_encoder: packs instruction fields into 16-bit words and streams them into program memory from address 0.
module prog_encoder #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [1:0]    in_src,
  input  logic [9:0]    in_value,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_code
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
  state_t state;
  logic accept, no_operand;
  logic [2:0] chk;
  logic [9:0] low;
  logic [15:0] word;
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  assign err = state == ERROR;
  assign accept = in_valid && in_ready;
  assign no_operand = in_opcode == 4'h0 || in_opcode == 4'hf;
  always_comb begin
    chk = no_operand ? 3'd0 :
          (in_src == 2'b01 && |in_value[9:8]) ? 3'd1 :
          (in_src[1] && |in_value[9:3]) ? 3'd2 :
          (in_opcode == 4'hc && in_src == 2'b01) ? 3'd3 : 3'd0;
    low = in_src == 2'b00 ? in_value :
          in_src == 2'b01 ? {2'b0, in_value[7:0]} : {7'b0, in_value[2:0]};
    word = no_operand ? {2'b00, in_opcode, 10'b0} : {in_src, in_opcode, low};
  end
  // count doubles as the next write address: it never exceeds DEPTH while in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      count <= '0;
      err_code <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state != LOAD && start) begin
        state <= LOAD;
        count <= '0;
        err_code <= '0;
      end else if (accept) begin
        if (chk != 3'd0) begin
          state <= ERROR;
          err_code <= chk;
        end else begin
          mem_we <= 1'b1;
          mem_addr <= count[AW-1:0];
          mem_wdata <= word;
          count <= count + 1'b1;
          if (in_last) state <= DONE;
          else if (&count[AW-1:0]) begin
            state <= ERROR;
            err_code <= 3'd4;
          end
        end
      end
    end
  end
endmodule
